// File: rtl/led_pkg.sv
// LED controller shared definitions: register byte offsets, mode encodings, period helper.
// Ports: none (package).
// Imported by led_ctrl_multi and led_tick_gen.
package led_pkg;

    // Byte offsets within the LED window (bit0 of the address is ignored)
    localparam logic [7:0] LED_DATA_LO = 8'h00;
    localparam logic [7:0] LED_DATA_HI = 8'h02;
    localparam logic [7:0] LED_CTRL    = 8'h04;
    localparam logic [7:0] LED_PERIOD  = 8'h06;

    typedef enum logic [1:0] {
        MODE_STATIC    = 2'b00,
        MODE_BLINK     = 2'b01,
        MODE_PWM       = 2'b10,
        MODE_BLINK_PWM = 2'b11
    } led_mode_e;

    // A programmed half-period of zero behaves as one tick
    function automatic logic [15:0] eff_period(input logic [15:0] p);
        return (p == 16'd0) ? 16'd1 : p;
    endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Blink prescaler: counts 0..TICK_DIV-1 and pulses o_tick for one cycle on the wrap value.
// Ports: led_clk/ledrst clock and async active-high reset, i_clr synchronous clear, o_tick pulse.
// i_clr restarts the count from 0 so a fresh blink period starts with a full tick interval.
module led_tick_gen
    import led_pkg::*;
#(
    parameter int TICK_DIV = 50000
) (
    input  logic led_clk,
    input  logic ledrst,
    input  logic i_clr,
    output logic o_tick
);

    localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] r_cnt;

    assign o_tick = (r_cnt == CW'(TICK_DIV - 1));

    always_ff @(posedge led_clk or posedge ledrst) begin
        if (ledrst) begin
            r_cnt <= '0;
        end else if (i_clr || o_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/led_ctrl_multi.sv
// Memory-mapped LED output controller with readback, global blink and PWM dimming.
// Ports: led_clk/ledrst clock and async active-high reset; ledcs/ledwrite/ledread/ledaddr/ledwdata bus in;
//        ledrdata registered read data (held between reads); ledout registered LED drive.
module led_ctrl_multi
    import led_pkg::*;
#(
    parameter int NUM_LED  = 24,
    parameter int ADDR_W   = 4,
    parameter int PWM_BITS = 8,
    parameter int TICK_DIV = 50000
) (
    input  logic                led_clk,
    input  logic                ledrst,
    input  logic                ledcs,
    input  logic                ledwrite,
    input  logic                ledread,
    input  logic [ADDR_W-1:0]   ledaddr,
    input  logic [15:0]         ledwdata,
    output logic [15:0]         ledrdata,
    output logic [NUM_LED-1:0]  ledout
);

    logic [NUM_LED-1:0]  r_pattern;
    logic [1:0]          r_mode;
    logic [PWM_BITS-1:0] r_duty;
    logic [15:0]         r_period;
    logic [15:0]         r_bcnt;
    logic                r_phase;
    logic [PWM_BITS-1:0] r_pwm_cnt;
    logic [NUM_LED-1:0]  r_ledout;
    logic [15:0]         r_rdata;

    logic [7:0]          w_off;
    logic                w_wr;
    logic                w_rd;
    logic                w_cfg_wr;
    logic                w_tick;
    logic [NUM_LED-1:0]  w_pat_nx;
    logic [15:0]         w_rd_lo;
    logic [15:0]         w_rd_hi;
    logic [15:0]         w_rd_mux;
    logic                w_blink_en;
    logic                w_pwm_en;
    logic                w_en;

    assign w_off    = 8'(ledaddr) & 8'hFE;
    assign w_wr     = ledcs && ledwrite;
    assign w_rd     = ledcs && ledread;
    // CTRL and PERIOD writes restart the blink sequence in the "on" phase
    assign w_cfg_wr = w_wr && ((w_off == LED_CTRL) || (w_off == LED_PERIOD));

    led_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .led_clk (led_clk),
        .ledrst  (ledrst),
        .i_clr   (w_cfg_wr),
        .o_tick  (w_tick)
    );

    // Halfword pattern update; bits beyond NUM_LED in DATA_HI are dropped
    always_comb begin
        w_pat_nx = r_pattern;
        for (int i = 0; i < NUM_LED; i++) begin
            if (i < 16 && w_wr && w_off == LED_DATA_LO) w_pat_nx[i] = ledwdata[i % 16];
            if (i >= 16 && w_wr && w_off == LED_DATA_HI) w_pat_nx[i] = ledwdata[i % 16];
        end
    end

    // Readback halves, zero-filled above NUM_LED
    always_comb begin
        w_rd_lo = '0;
        w_rd_hi = '0;
        for (int j = 0; j < 16; j++) begin
            if (j < NUM_LED)      w_rd_lo[j] = r_pattern[j % NUM_LED];
            if (j + 16 < NUM_LED) w_rd_hi[j] = r_pattern[(j + 16) % NUM_LED];
        end
    end

    always_comb begin
        w_rd_mux = '0;
        case (w_off)
            LED_DATA_LO: w_rd_mux = w_rd_lo;
            LED_DATA_HI: w_rd_mux = w_rd_hi;
            LED_CTRL:    w_rd_mux = 16'(r_mode) | (16'(r_duty) << 8);
            LED_PERIOD:  w_rd_mux = r_period;
            default:     w_rd_mux = '0;
        endcase
    end

    assign w_blink_en = (r_mode == MODE_BLINK) || (r_mode == MODE_BLINK_PWM);
    assign w_pwm_en   = (r_mode == MODE_PWM)   || (r_mode == MODE_BLINK_PWM);
    assign w_en       = (!w_blink_en || r_phase) && (!w_pwm_en || (r_pwm_cnt < r_duty));

    // Register file
    always_ff @(posedge led_clk or posedge ledrst) begin
        if (ledrst) begin
            r_pattern <= '0;
            r_mode    <= MODE_STATIC;
            r_duty    <= '0;
            r_period  <= 16'd1;
        end else begin
            r_pattern <= w_pat_nx;
            if (w_wr && w_off == LED_CTRL) begin
                r_mode <= ledwdata[1:0];
                r_duty <= ledwdata[8 +: PWM_BITS];
            end
            if (w_wr && w_off == LED_PERIOD) r_period <= ledwdata;
        end
    end

    // Blink counter and phase; the phase flips after eff_period ticks
    always_ff @(posedge led_clk or posedge ledrst) begin
        if (ledrst) begin
            r_bcnt  <= '0;
            r_phase <= 1'b1;
        end else if (w_cfg_wr) begin
            r_bcnt  <= '0;
            r_phase <= 1'b1;
        end else if (w_tick) begin
            if (r_bcnt >= eff_period(r_period) - 16'd1) begin
                r_bcnt  <= '0;
                r_phase <= !r_phase;
            end else begin
                r_bcnt <= r_bcnt + 16'd1;
            end
        end
    end

    // Free-running PWM counter, output and read-data registers
    always_ff @(posedge led_clk or posedge ledrst) begin
        if (ledrst) begin
            r_pwm_cnt <= '0;
            r_ledout  <= '0;
            r_rdata   <= '0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + 1'b1;
            r_ledout  <= r_pattern & {NUM_LED{w_en}};
            if (w_rd) r_rdata <= w_rd_mux;
        end
    end

    assign ledout   = r_ledout;
    assign ledrdata = r_rdata;

endmodule

// File: tb/tb_led_ctrl_multi.sv
module tb_led_ctrl_multi;

    localparam int NL   = 24;
    localparam int AW   = 4;
    localparam int PB   = 4;
    localparam int TDIV = 4;

    logic          led_clk = 1'b0;
    logic          ledrst;
    logic          ledcs, ledwrite, ledread;
    logic [AW-1:0] ledaddr;
    logic [15:0]   ledwdata;
    logic [15:0]   ledrdata;
    logic [NL-1:0] ledout;

    int checks = 0;
    int errors = 0;

    led_ctrl_multi #(.NUM_LED(NL), .ADDR_W(AW), .PWM_BITS(PB), .TICK_DIV(TDIV)) dut (
        .led_clk  (led_clk),
        .ledrst   (ledrst),
        .ledcs    (ledcs),
        .ledwrite (ledwrite),
        .ledread  (ledread),
        .ledaddr  (ledaddr),
        .ledwdata (ledwdata),
        .ledrdata (ledrdata),
        .ledout   (ledout)
    );

    always #5 led_clk = ~led_clk;

    // Reference model: register contents plus elapsed-cycle counts.
    // m_k = cycles since last CTRL/PERIOD write (or reset), m_n = cycles since reset.
    logic [23:0] m_pat;
    logic [1:0]  m_mode;
    logic [3:0]  m_duty;
    logic [15:0] m_period;
    int          m_k, m_n;
    logic [15:0] m_rdata;
    logic [23:0] m_led;

    function automatic logic model_en();
        int  p;
        logic ph, pw;
        p  = (m_period == 0) ? 1 : int'(m_period);
        ph = (((m_k / TDIV) / p) % 2) == 0;
        pw = (m_n % 16) < int'(m_duty);
        return (!m_mode[0] || ph) && (!m_mode[1] || pw);
    endfunction

    function automatic logic [15:0] model_read(input logic [3:0] a);
        case (a & 4'hE)
            4'h0:    return m_pat[15:0];
            4'h2:    return {8'h00, m_pat[23:16]};
            4'h4:    return {4'h0, m_duty, 6'h00, m_mode};
            4'h6:    return m_period;
            default: return 16'h0000;
        endcase
    endfunction

    task automatic model_reset();
        m_pat = '0; m_mode = '0; m_duty = '0; m_period = 16'd1;
        m_k = 0; m_n = 0; m_rdata = '0; m_led = '0;
    endtask

    task automatic model_edge(input logic cs, wr, rd, input logic [3:0] a, input logic [15:0] wd);
        logic [23:0] nled;
        nled = model_en() ? m_pat : 24'h0;
        if (cs && rd) m_rdata = model_read(a);
        m_k++; m_n++;
        if (cs && wr) begin
            case (a & 4'hE)
                4'h0: m_pat[15:0] = wd;
                4'h2: m_pat[23:16] = wd[7:0];
                4'h4: begin m_mode = wd[1:0]; m_duty = wd[11:8]; m_k = 0; end
                4'h6: begin m_period = wd; m_k = 0; end
                default: ;
            endcase
        end
        m_led = nled;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // One bus cycle: drive, clock, update model, sample 1 time unit after the edge
    task automatic step(input logic cs, wr, rd, input logic [3:0] a, input logic [15:0] wd);
        ledcs = cs; ledwrite = wr; ledread = rd; ledaddr = a; ledwdata = wd;
        @(posedge led_clk);
        model_edge(cs, wr, rd, a, wd);
        #1;
        chk("model_ledout", 32'(ledout), 32'(m_led));
        chk("model_rdata", 32'(ledrdata), 32'(m_rdata));
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 4'h0, 16'h0);
    endtask

    typedef struct {
        logic        cs, wr, rd;
        logic [3:0]  addr;
        logic [15:0] wd;
        logic [23:0] exp_led;
        logic [15:0] exp_rd;
    } vec_t;

    vec_t tbl[15];

    initial begin
        int on_cnt;

        tbl[0]  = '{1'b1, 1'b1, 1'b0, 4'h0, 16'hA5A5, 24'h000000, 16'h0000};
        tbl[1]  = '{1'b1, 1'b1, 1'b0, 4'h2, 16'h00C3, 24'h00A5A5, 16'h0000};
        tbl[2]  = '{1'b1, 1'b0, 1'b1, 4'h2, 16'h0000, 24'hC3A5A5, 16'h00C3};
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 4'h2, 16'hFFFF, 24'hC3A5A5, 16'h00C3};
        tbl[4]  = '{1'b1, 1'b0, 1'b1, 4'h2, 16'h0000, 24'hFFA5A5, 16'h00FF};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 4'hE, 16'h1234, 24'hFFA5A5, 16'h00FF};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 4'h0, 16'h0000, 24'hFFA5A5, 16'h00FF};
        tbl[7]  = '{1'b1, 1'b0, 1'b1, 4'h0, 16'h0000, 24'hFFA5A5, 16'hA5A5};
        tbl[8]  = '{1'b1, 1'b0, 1'b1, 4'hE, 16'h0000, 24'hFFA5A5, 16'h0000};
        tbl[9]  = '{1'b1, 1'b0, 1'b1, 4'h4, 16'h0000, 24'hFFA5A5, 16'h0000};
        tbl[10] = '{1'b1, 1'b0, 1'b1, 4'h6, 16'h0000, 24'hFFA5A5, 16'h0001};
        tbl[11] = '{1'b1, 1'b1, 1'b1, 4'h0, 16'h1111, 24'hFFA5A5, 16'hA5A5};
        tbl[12] = '{1'b1, 1'b0, 1'b1, 4'h0, 16'h0000, 24'hFF1111, 16'h1111};
        tbl[13] = '{1'b1, 1'b0, 1'b1, 4'h1, 16'h0000, 24'hFF1111, 16'h1111};
        tbl[14] = '{1'b0, 1'b0, 1'b1, 4'h6, 16'h0000, 24'hFF1111, 16'h1111};

        // Reset
        ledrst = 1'b1; ledcs = 1'b0; ledwrite = 1'b0; ledread = 1'b0;
        ledaddr = '0; ledwdata = '0;
        model_reset();
        #12;
        chk("reset_ledout", 32'(ledout), 32'h0);
        chk("reset_rdata", 32'(ledrdata), 32'h0);
        ledrst = 1'b0;

        // Table-driven static / masking / unmapped / cs-low vectors
        for (int i = 0; i < 15; i++) begin
            step(tbl[i].cs, tbl[i].wr, tbl[i].rd, tbl[i].addr, tbl[i].wd);
            chk($sformatf("tbl%0d_ledout", i), 32'(ledout), 32'(tbl[i].exp_led));
            chk($sformatf("tbl%0d_rdata", i), 32'(ledrdata), 32'(tbl[i].exp_rd));
        end

        // Blink: PERIOD=3, TICK_DIV=4 -> 12 cycles on, 12 off
        step(1'b1, 1'b1, 1'b0, 4'h0, 16'hFFFF);
        step(1'b1, 1'b1, 1'b0, 4'h2, 16'h00FF);
        step(1'b1, 1'b1, 1'b0, 4'h6, 16'h0003);
        step(1'b1, 1'b1, 1'b0, 4'h4, 16'h0001);
        for (int j = 0; j < 48; j++) begin
            idle();
            chk($sformatf("blink_%0d", j), 32'(ledout), ((j / 12) % 2 == 0) ? 32'hFFFFFF : 32'h0);
        end

        // PWM duty 4, 0 and max over 16-cycle windows
        step(1'b1, 1'b1, 1'b0, 4'h4, 16'h0402);
        on_cnt = 0;
        for (int j = 0; j < 16; j++) begin idle(); if (ledout == 24'hFFFFFF) on_cnt++; end
        chk("pwm_duty4_on", 32'(on_cnt), 32'd4);
        step(1'b1, 1'b1, 1'b0, 4'h4, 16'h0002);
        on_cnt = 0;
        for (int j = 0; j < 16; j++) begin idle(); if (ledout != 24'h0) on_cnt++; end
        chk("pwm_duty0_on", 32'(on_cnt), 32'd0);
        step(1'b1, 1'b1, 1'b0, 4'h4, 16'h0F02);
        on_cnt = 0;
        for (int j = 0; j < 16; j++) begin idle(); if (ledout == 24'hFFFFFF) on_cnt++; end
        chk("pwm_dutymax_on", 32'(on_cnt), 32'd15);

        // Reset mid-blink: outputs clear without waiting for a clock edge
        step(1'b1, 1'b1, 1'b0, 4'h4, 16'h0001);
        step(1'b1, 1'b0, 1'b1, 4'h6, 16'h0000);
        idle();
        chk("preblink_ledout", 32'(ledout), 32'hFFFFFF);
        #1;
        ledrst = 1'b1;
        #1;
        chk("midrst_ledout", 32'(ledout), 32'h0);
        chk("midrst_rdata", 32'(ledrdata), 32'h0);
        model_reset();
        #4;
        ledrst = 1'b0;
        step(1'b1, 1'b0, 1'b1, 4'h4, 16'h0000);
        chk("postrst_ctrl", 32'(ledrdata), 32'h0);
        step(1'b1, 1'b0, 1'b1, 4'h6, 16'h0000);
        chk("postrst_period", 32'(ledrdata), 32'h1);
        step(1'b1, 1'b0, 1'b1, 4'h0, 16'h0000);
        chk("postrst_data", 32'(ledrdata), 32'h0);

        // Randomized traffic against the model
        for (int j = 0; j < 600; j++) begin
            logic        cs, wr, rd;
            logic [3:0]  a;
            logic [15:0] wd;
            cs = ($urandom_range(0, 3) != 0);
            wr = ($urandom_range(0, 4) == 0);
            rd = ($urandom_range(0, 1) == 1);
            a  = 4'($urandom_range(0, 15));
            wd = 16'($urandom);
            if ((a & 4'hE) == 4'h6) wd = 16'($urandom_range(0, 3));
            step(cs, wr, rd, a, wd);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
